// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: schedule-reader FSM encoding, block geometry and
// the small-sigma functions also used by the compression core.
package sha256_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int ROUNDS          = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msg_schedule_reader_if.sv
// Schedule-word stream from the reader (master) to the compression core (slave).
interface msg_schedule_reader_if;
  // A word transfers on every clock edge where w_valid && w_ready. Once w_valid
  // is high, w_data/w_idx/block_idx/block_last hold until that transfer, and
  // w_valid never depends combinationally on w_ready.
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  w_idx;
  logic        block_idx;
  logic        block_last;

  modport master (
    output w_data, w_valid, w_idx, block_idx, block_last,
    input  w_ready
  );

  modport slave (
    input  w_data, w_valid, w_idx, block_idx, block_last,
    output w_ready
  );
endinterface

// File: rtl/msg_expand.sv
// Combinational SHA-256 schedule step: given the window W[t-15..t] (W[t] in the
// top entry), produce W[t+1] for t >= 15.
module msg_expand
  import sha256_pkg::*;
(
  input  logic [31:0] i_window [16],
  output logic [31:0] o_w_next
);

  // Entry i holds W[t-15+i]: W[t-1]=14, W[t-6]=9, W[t-14]=1, W[t-15]=0.
  assign o_w_next = sigma1(i_window[14]) + i_window[9]
                  + sigma0(i_window[1])  + i_window[0];

endmodule

// File: rtl/msg_schedule_reader.sv
// Reads one or two padded 512-bit blocks from the regfile and streams the
// expanded 64-word message schedule of each block over a valid/ready port.
module msg_schedule_reader
  import sha256_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   blocks_num,
  input  logic [31:0]                  padded_message,
  output logic [4:0]                   addr_rd,
  msg_schedule_reader_if.master        w_if,
  output logic                         busy,
  output logic                         done,
  output state_t                       dbg_state
);

  localparam logic [5:0] LAST_IDX       = 6'(ROUNDS - 1);
  localparam logic [5:0] LAST_FETCH_IDX = 6'(WORDS_PER_BLOCK - 1);
  localparam logic [5:0] LAST_ADDR_STEP = 6'(WORDS_PER_BLOCK - 2);

  state_t      r_state;
  logic        r_two_blk;
  logic        r_block_idx;
  logic        r_block_last;
  logic        r_w_valid;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_w_idx;
  logic [4:0]  r_addr_rd;
  // The top entry is the word currently presented on w_data.
  logic [31:0] r_window [16];

  logic [31:0] w_expanded;
  logic [31:0] w_next_word;
  logic        w_hs;
  logic        w_unused;

  msg_expand u_expand (
    .i_window (r_window),
    .o_w_next (w_expanded)
  );

  assign w_hs        = r_w_valid && w_if.w_ready;
  assign w_next_word = (r_w_idx < LAST_FETCH_IDX) ? padded_message : w_expanded;
  assign w_unused    = blocks_num[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_two_blk    <= 1'b0;
      r_block_idx  <= 1'b0;
      r_block_last <= 1'b0;
      r_w_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_w_idx      <= '0;
      r_addr_rd    <= '0;
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_two_blk    <= blocks_num[0];
            r_block_idx  <= 1'b0;
            r_block_last <= ~blocks_num[0];
            r_busy       <= 1'b1;
            r_addr_rd    <= 5'd0;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
          r_window[15] <= padded_message;
          r_w_idx      <= '0;
          r_w_valid    <= 1'b1;
          r_addr_rd    <= {r_block_idx, 4'd1};
          r_state      <= STREAM;
        end
        STREAM: begin
          if (w_hs) begin
            if (r_w_idx == LAST_IDX) begin
              r_w_valid <= 1'b0;
              if (r_two_blk && !r_block_idx) begin
                r_block_idx  <= 1'b1;
                r_block_last <= 1'b1;
                r_addr_rd    <= 5'd16;
                r_state      <= FETCH;
              end else begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end else begin
              for (int i = 0; i < 15; i++) r_window[i] <= r_window[i+1];
              r_window[15] <= w_next_word;
              r_w_idx      <= r_w_idx + 6'd1;
              // Pre-address the regfile word needed at the following handshake.
              if (r_w_idx < LAST_ADDR_STEP)
                r_addr_rd <= {r_block_idx, r_w_idx[3:0] + 4'd2};
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign addr_rd         = r_addr_rd;
  assign w_if.w_data     = r_window[15];
  assign w_if.w_valid    = r_w_valid;
  assign w_if.w_idx      = r_w_idx;
  assign w_if.block_idx  = r_block_idx;
  assign w_if.block_last = r_block_last;
  assign busy            = r_busy;
  assign done            = r_done;
  assign dbg_state       = r_state;

endmodule
